// File: rtl/lsu_ctrl.sv
// Load/store bus controller: accepts EX-stage requests, runs the req/gnt/rvalid
// handshake, and hands the raw load word plus its size/offset to select_rd.

package selectPkg;
    typedef enum logic [2:0] {
        SB  = 3'd0,
        SH  = 3'd1,
        SW  = 3'd2,
        SBU = 3'd3,
        SHU = 3'd4
    } sel_type;
endpackage

module lsu_ctrl #(
    parameter int REG_LEN  = 32,
    parameter int ADDR_LEN = 32,
    parameter int TIMEOUT  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ld_req_i,
    input  logic                    st_req_i,
    input  selectPkg::sel_type      sel_type_i,
    input  logic [ADDR_LEN-1:0]     addr_i,
    input  logic [REG_LEN-1:0]      wdata_i,
    output logic                    busy_o,
    output logic                    misalign_o,
    output logic                    bus_err_o,
    output logic                    bus_req_o,
    output logic                    bus_we_o,
    output logic [ADDR_LEN-1:0]     bus_addr_o,
    output logic [REG_LEN/8-1:0]    bus_be_o,
    output logic [REG_LEN-1:0]      bus_wdata_o,
    input  logic                    bus_gnt_i,
    input  logic                    bus_rvalid_i,
    input  logic [REG_LEN-1:0]      bus_rdata_i,
    output logic [REG_LEN-1:0]      rdata_o,
    output logic                    rdata_valid_o,
    output selectPkg::sel_type      sel_type_old_o,
    output logic [1:0]              sel_addr_old_o
);
    import selectPkg::*;

    localparam int BE_LEN = REG_LEN / 8;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_e;

    state_e               state_q;
    logic                 bus_req_q, bus_we_q;
    logic [ADDR_LEN-1:0]  bus_addr_q;
    logic [BE_LEN-1:0]    bus_be_q;
    logic [REG_LEN-1:0]   bus_wdata_q;
    logic [REG_LEN-1:0]   rdata_q;
    logic                 rdata_valid_q, misalign_q, bus_err_q;
    sel_type              sel_type_old_q;
    logic [1:0]           sel_addr_old_q;
    logic [CNT_W-1:0]     cnt_q;

    logic                 req_d, misaligned_d, accept_d;
    logic [BE_LEN-1:0]    be_d;
    logic [REG_LEN-1:0]   wdata_d;
    logic [CNT_W-1:0]     cnt_d;

    always_comb begin
        req_d        = ld_req_i | st_req_i;
        misaligned_d = 1'b0;
        be_d         = '0;
        wdata_d      = '0;
        case (sel_type_i)
            SB, SBU: begin
                be_d    = BE_LEN'(1) << addr_i[1:0];
                wdata_d = {BE_LEN{wdata_i[7:0]}};
            end
            SH, SHU: begin
                misaligned_d = addr_i[0];
                be_d         = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_d      = {(REG_LEN/16){wdata_i[15:0]}};
            end
            SW: begin
                misaligned_d = (addr_i[1:0] != 2'b00);
                be_d         = '1;
                wdata_d      = wdata_i;
            end
            default: ;
        endcase
        // Store wins when both requests are high; loads drive no write data.
        if (!st_req_i) wdata_d = '0;
        accept_d = (state_q == IDLE) && req_d && !misaligned_d;
        busy_o   = (state_q != IDLE) || accept_d;
        cnt_d    = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bus_req_q      <= 1'b0;
            bus_we_q       <= 1'b0;
            bus_addr_q     <= '0;
            bus_be_q       <= '0;
            bus_wdata_q    <= '0;
            rdata_q        <= '0;
            rdata_valid_q  <= 1'b0;
            misalign_q     <= 1'b0;
            bus_err_q      <= 1'b0;
            sel_type_old_q <= SW;
            sel_addr_old_q <= 2'b00;
            cnt_q          <= '0;
        end else begin
            misalign_q    <= 1'b0;
            bus_err_q     <= 1'b0;
            rdata_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        bus_req_q      <= 1'b1;
                        bus_we_q       <= st_req_i;
                        bus_addr_q     <= {addr_i[ADDR_LEN-1:2], 2'b00};
                        bus_be_q       <= be_d;
                        bus_wdata_q    <= wdata_d;
                        sel_type_old_q <= sel_type_i;
                        sel_addr_old_q <= addr_i[1:0];
                        state_q        <= REQ;
                    end else if (req_d) begin
                        misalign_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus_gnt_i) begin
                        bus_req_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= bus_we_q ? IDLE : WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (bus_rvalid_i) begin
                        rdata_q       <= bus_rdata_i;
                        rdata_valid_q <= 1'b1;
                        state_q       <= IDLE;
                    end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                        bus_err_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_req_o      = bus_req_q;
    assign bus_we_o       = bus_we_q;
    assign bus_addr_o     = bus_addr_q;
    assign bus_be_o       = bus_be_q;
    assign bus_wdata_o    = bus_wdata_q;
    assign rdata_o        = rdata_q;
    assign rdata_valid_o  = rdata_valid_q;
    assign misalign_o     = misalign_q;
    assign bus_err_o      = bus_err_q;
    assign sel_type_old_o = sel_type_old_q;
    assign sel_addr_old_o = sel_addr_old_q;

endmodule
